// File: rtl/bitrev_reorder.sv
// Ping-pong reorder buffer: FFT samples arrive in bit-reversed order and leave in
// natural order with a valid/ready handshake, one sample per clock when unstalled.
module bitrev_reorder #(
    parameter int LOGN = 6,
    parameter int DW   = 16
) (
    input  logic            iCLK,
    input  logic            iRSTn,
    input  logic            iCLR,
    input  logic            iVALID,
    input  logic [LOGN-1:0] iIDX,
    input  logic [DW-1:0]   iDATA_I,
    input  logic [DW-1:0]   iDATA_Q,
    output logic            oFULL,
    output logic            oOVF,
    input  logic            iREADY,
    output logic            oVALID,
    output logic [LOGN-1:0] oIDX,
    output logic            oSOF,
    output logic            oEOF,
    output logic [DW-1:0]   oDATA_I,
    output logic [DW-1:0]   oDATA_Q
);
    localparam int N = 1 << LOGN;
    localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

    typedef struct packed {
        logic [DW-1:0] i;
        logic [DW-1:0] q;
    } sample_t;

    typedef enum logic {R_IDLE, R_READ} rstate_t;

    sample_t         mem [0:1][0:N-1];
    sample_t         rdData;
    logic [1:0]      full;
    logic            wrBank, rdBank;
    logic [LOGN-1:0] wrAddr, rdAddr;
    rstate_t         rState;
    logic            wrEn, advance, fetch;

    for (genvar b = 0; b < LOGN; b++) begin : g_rev
        assign wrAddr[b] = iIDX[LOGN-1-b];
    end

    assign oFULL   = full[wrBank];
    assign wrEn    = iVALID && !oFULL;
    assign advance = !oVALID || iREADY;
    assign fetch   = advance && (rState == R_READ || full[rdBank]);
    assign rdData  = mem[rdBank][rdAddr];

    always_ff @(posedge iCLK) begin
        if (wrEn) mem[wrBank][wrAddr] <= {iDATA_I, iDATA_Q};
    end

    always_ff @(posedge iCLK) begin
        if (!iRSTn || iCLR) begin
            full    <= '0;
            wrBank  <= 1'b0;
            rdBank  <= 1'b0;
            rdAddr  <= '0;
            rState  <= R_IDLE;
            oOVF    <= 1'b0;
            oVALID  <= 1'b0;
            oIDX    <= '0;
            oSOF    <= 1'b0;
            oEOF    <= 1'b0;
            oDATA_I <= '0;
            oDATA_Q <= '0;
        end else begin
            if (iVALID && oFULL) oOVF <= 1'b1;

            if (wrEn && iIDX == LAST) begin
                full[wrBank] <= 1'b1;
                wrBank       <= ~wrBank;
            end

            // The output register is the read pipeline stage; it only moves when unstalled.
            if (fetch) begin
                oVALID  <= 1'b1;
                oIDX    <= rdAddr;
                oSOF    <= (rdAddr == '0);
                oEOF    <= (rdAddr == LAST);
                oDATA_I <= rdData.i;
                oDATA_Q <= rdData.q;
                rdAddr  <= rdAddr + 1'b1;
            end else if (advance) begin
                oVALID  <= 1'b0;
            end

            case (rState)
                R_IDLE: if (fetch) rState <= R_READ;
                R_READ: begin
                    // The bank is released once its last sample sits in the output
                    // register, so upstream can refill it without a gap between frames.
                    if (fetch && rdAddr == LAST) begin
                        full[rdBank] <= 1'b0;
                        rdBank       <= ~rdBank;
                        rState       <= R_IDLE;
                    end
                end
                default: rState <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bitrev_reorder.sv
// Directed + randomized bench for bitrev_reorder (N=8) with a frame-level reference model.
module tb_bitrev_reorder;
    localparam int LOGN = 3;
    localparam int DW   = 16;
    localparam int N    = 1 << LOGN;

    logic            iCLK, iRSTn, iCLR, iVALID, iREADY;
    logic [LOGN-1:0] iIDX;
    logic [DW-1:0]   iDATA_I, iDATA_Q;
    logic            oFULL, oOVF, oVALID, oSOF, oEOF;
    logic [LOGN-1:0] oIDX;
    logic [DW-1:0]   oDATA_I, oDATA_Q;

    bitrev_reorder #(.LOGN(LOGN), .DW(DW)) dut (
        .iCLK(iCLK), .iRSTn(iRSTn), .iCLR(iCLR), .iVALID(iVALID), .iIDX(iIDX),
        .iDATA_I(iDATA_I), .iDATA_Q(iDATA_Q), .oFULL(oFULL), .oOVF(oOVF),
        .iREADY(iREADY), .oVALID(oVALID), .oIDX(oIDX), .oSOF(oSOF), .oEOF(oEOF),
        .oDATA_I(oDATA_I), .oDATA_Q(oDATA_Q)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int tests = 0;
    int fails = 0;
    logic [2*DW-1:0]      fbuf [N];
    logic [LOGN+2*DW-1:0] expq [$];
    logic [DW-1:0]        logq [$];
    int fullCnt = 0;
    int run = 0;
    int maxRun = 0;
    bit rr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rev(input int x);
        int r = 0;
        for (int k = 0; k < LOGN; k++) r = r * 2 + ((x >> k) & 1);
        return r;
    endfunction

    // Scoreboard: every handshake must match the next natural-order sample of a closed frame.
    always @(negedge iCLK) begin
        logic [LOGN+2*DW-1:0] e;
        if (oFULL === 1'b1) fullCnt++;
        if (oVALID === 1'b1) begin
            run++;
            if (run > maxRun) maxRun = run;
        end else run = 0;
        if (oVALID === 1'b1 && iREADY === 1'b1) begin
            chk("xfer_expected", 64'(expq.size() != 0), 64'd1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("out_idx", 64'(oIDX), 64'(e[LOGN+2*DW-1:2*DW]));
                chk("out_data", 64'({oDATA_I, oDATA_Q}), 64'(e[2*DW-1:0]));
                chk("out_sof", 64'(oSOF), 64'(e[LOGN+2*DW-1:2*DW] == 0));
                chk("out_eof", 64'(oEOF), 64'(e[LOGN+2*DW-1:2*DW] == N - 1));
                logq.push_back(oDATA_I);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    // Upstream write that honours oFULL; the model records the sample once accepted.
    task automatic wr(input int idx, input logic [2*DW-1:0] d);
        int n = 0;
        while (oFULL && n < 200) begin
            iVALID = 1'b0;
            if (rr) iREADY = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        chk("wr_wait_bound", 64'(n < 200), 64'd1);
        iVALID = 1'b1;
        iIDX = LOGN'(idx);
        {iDATA_I, iDATA_Q} = d;
        if (rr) iREADY = 1'($urandom_range(0, 1));
        step();
        fbuf[idx] = d;
        if (idx == N - 1)
            for (int a = 0; a < N; a++) expq.push_back({LOGN'(a), fbuf[rev(a)]});
    endtask

    task automatic frame_rand();
        for (int k = 0; k < N; k++) wr(k, 32'($urandom));
    endtask

    task automatic frame_idx();
        for (int k = 0; k < N; k++) wr(k, {DW'(k), DW'($urandom)});
    endtask

    task automatic drain();
        int n = 0;
        iVALID = 1'b0;
        while ((expq.size() != 0 || oVALID) && n < 400) begin
            if (rr) iREADY = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        chk("drain_bound", 64'(expq.size() == 0 && !oVALID), 64'd1);
        iREADY = 1'b1;
    endtask

    task automatic chk_table();
        int tbl [N] = '{0, 4, 2, 6, 1, 5, 3, 7};
        chk("table_len", 64'(logq.size()), 64'(N));
        for (int k = 0; k < N && k < logq.size(); k++) chk("table_data", 64'(logq[k]), 64'(tbl[k]));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_valid"}, 64'(oVALID), 64'd0);
        chk({tag, "_full"}, 64'(oFULL), 64'd0);
        chk({tag, "_ovf"}, 64'(oOVF), 64'd0);
        chk({tag, "_sof"}, 64'(oSOF), 64'd0);
        chk({tag, "_eof"}, 64'(oEOF), 64'd0);
        chk({tag, "_idx"}, 64'(oIDX), 64'd0);
        chk({tag, "_data"}, 64'({oDATA_I, oDATA_Q}), 64'd0);
    endtask

    initial begin
        int n, fc0;
        iRSTn = 1'b0; iCLR = 1'b0; iVALID = 1'b0; iREADY = 1'b1;
        iIDX = '0; iDATA_I = '0; iDATA_Q = '0;
        step(); step();
        chk_reset_outs("reset");
        iRSTn = 1'b1;
        step();

        // Single frame: latency and natural-order sequence.
        logq.delete();
        frame_idx();
        iVALID = 1'b0;
        chk("lat_cycle1_valid", 64'(oVALID), 64'd0);
        step();
        chk("lat_cycle2_valid", 64'(oVALID), 64'd1);
        chk("lat_cycle2_sof", 64'(oSOF), 64'd1);
        drain();
        chk_table();

        // Three frames back to back.
        fc0 = fullCnt;
        frame_rand(); frame_rand(); frame_rand();
        drain();
        chk("b2b_full_never", 64'(fullCnt - fc0), 64'd0);
        chk("b2b_run", 64'(maxRun), 64'd24);

        // Stall for 3 cycles while oIDX=3 is presented.
        iREADY = 1'b1;
        frame_rand();
        iVALID = 1'b0;
        n = 0;
        while (!(oVALID && oIDX == 3) && n < 50) begin step(); n++; end
        chk("stall_reach", 64'(n < 50), 64'd1);
        iREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_idx", 64'(oIDX), 64'd3);
            chk("stall_data", 64'({oDATA_I, oDATA_Q}), 64'(fbuf[rev(3)]));
            chk("stall_valid", 64'(oVALID), 64'd1);
        end
        iREADY = 1'b1;
        drain();

        // Overflow: two frames held back, one extra sample dropped.
        iREADY = 1'b0;
        frame_rand(); frame_rand();
        iVALID = 1'b0;
        chk("ovf_full", 64'(oFULL), 64'd1);
        chk("ovf_pre", 64'(oOVF), 64'd0);
        iVALID = 1'b1; iIDX = '0; {iDATA_I, iDATA_Q} = 32'hdead_beef;
        step();
        iVALID = 1'b0;
        chk("ovf_set", 64'(oOVF), 64'd1);
        iREADY = 1'b1;
        chk("ovf_full_first", 64'(oFULL), 64'd1);
        n = 0;
        while (!(oVALID && oEOF) && n < 50) begin step(); n++; end
        chk("ovf_eof_reach", 64'(n < 50), 64'd1);
        step();
        chk("ovf_full_fall", 64'(oFULL), 64'd0);
        drain();
        chk("ovf_sticky", 64'(oOVF), 64'd1);

        // Clear at oIDX=5 while the other bank is full.
        iREADY = 1'b0;
        frame_rand(); frame_rand();
        iVALID = 1'b0;
        iREADY = 1'b1;
        n = 0;
        while (!(oVALID && oIDX == 5) && n < 50) begin step(); n++; end
        chk("clr_reach", 64'(n < 50), 64'd1);
        iCLR = 1'b1;
        step();
        iCLR = 1'b0;
        expq.delete();
        chk("clr_valid", 64'(oVALID), 64'd0);
        chk("clr_full", 64'(oFULL), 64'd0);
        chk("clr_ovf", 64'(oOVF), 64'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("clr_no_stale", 64'(oVALID), 64'd0);
        end
        frame_rand();
        drain();

        // Reset pulse mid-write at iIDX=4.
        for (int k = 0; k < 4; k++) wr(k, 32'($urandom));
        iVALID = 1'b1; iIDX = 3'd4; {iDATA_I, iDATA_Q} = 32'h1234_5678;
        iRSTn = 1'b0;
        step();
        iRSTn = 1'b1; iVALID = 1'b0;
        expq.delete();
        chk_reset_outs("midrst");
        step();
        chk("midrst_no_stale", 64'(oVALID), 64'd0);
        logq.delete();
        frame_idx();
        drain();
        chk_table();

        // Random data, random downstream ready, random upstream gaps.
        rr = 1;
        for (int f = 0; f < 4; f++)
            for (int k = 0; k < N; k++) begin
                wr(k, 32'($urandom));
                if ($urandom_range(0, 3) == 0) begin iVALID = 1'b0; step(); end
            end
        drain();
        rr = 0;
        chk("rand_no_ovf", 64'(oOVF), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
